riscy_pipe_core: RTL

RISCY_PIPE_CORE -- requirements
Module: riscy_pipe_core

---
 rtl/riscy_pkg.sv | 47 ++++
 rtl/riscy_alu.sv | 38 +++
 rtl/riscy_pipe_core.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/riscy_pkg.sv
`default_nettype none
// ============================================================================
// riscy_pkg: opcodes, control-state encoding and instruction field positions.
// Rev 1.0
// ============================================================================
package riscy_pkg;

    typedef logic [3:0] opcode_t;
    typedef logic [3:0] reg_idx_t;

    localparam opcode_t OP_HLT = 4'h0;
    localparam opcode_t OP_MOV = 4'h1;
    localparam opcode_t OP_MVI = 4'h2;
    localparam opcode_t OP_LOD = 4'h3;
    localparam opcode_t OP_STR = 4'h4;
    localparam opcode_t OP_ADD = 4'h5;
    localparam opcode_t OP_SUB = 4'h6;
    localparam opcode_t OP_MUL = 4'h7;
    localparam opcode_t OP_AND = 4'h8;
    localparam opcode_t OP_ORR = 4'h9;
    localparam opcode_t OP_NOT = 4'hA;
    localparam opcode_t OP_LES = 4'hB;
    localparam opcode_t OP_GTR = 4'hC;
    localparam opcode_t OP_JEZ = 4'hD;
    localparam opcode_t OP_JNZ = 4'hE;
    localparam opcode_t OP_JMP = 4'hF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int OPC_MSB = 31;
    localparam int RD_MSB  = 27;
    localparam int RA_MSB  = 23;
    localparam int RB_MSB  = 19;
    localparam int IMM_MSB = 15;

    function automatic logic writes_rd(input opcode_t op);
        case (op)
            OP_HLT, OP_STR, OP_JEZ, OP_JNZ, OP_JMP: return 1'b0;
            default:                                return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscy_alu.sv
`default_nettype none
// ============================================================================
// riscy_alu: combinational ALU; JEZ/JNZ pass operand a through so zero_o tests it.
// Rev 1.0
// ============================================================================
module riscy_alu
    import riscy_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  opcode_t           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_MOV, OP_JEZ, OP_JNZ: result_o = a_i;
            OP_MVI:                 result_o = b_i;
            OP_ADD:                 result_o = a_i + b_i;
            OP_SUB:                 result_o = a_i - b_i;
            OP_MUL:                 result_o = a_i * b_i;
            OP_AND:                 result_o = a_i & b_i;
            OP_ORR:                 result_o = a_i | b_i;
            OP_NOT:                 result_o = ~a_i;
            OP_LES:                 result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            OP_GTR:                 result_o = {{(DATA_W-1){1'b0}}, (a_i > b_i)};
            default:                result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule
`default_nettype wire

// File: rtl/riscy_pipe_core.sv
`default_nettype none
// ============================================================================
// riscy_pipe_core: four-stage (IF/ID/EX/WB) in-order core with full forwarding.
// Rev 1.0
// ============================================================================
module riscy_pipe_core
    import riscy_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    input  logic [3:0]         dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic               halted,
    output logic               retire_valid,
    output logic [IMEM_AW-1:0] retire_pc
);

    logic [31:0]        imem_q [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem_q [2**DMEM_AW];
    logic [DATA_W-1:0]  regs_q [16];

    logic [1:0]         state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic               if_valid_q, if_valid_d;

    logic               id_valid_q, id_valid_d;
    logic [31:0]        id_instr_q;
    logic [IMEM_AW-1:0] id_pc_q;

    logic               ex_valid_q, ex_valid_d;
    opcode_t            ex_op_q;
    reg_idx_t           ex_rd_q;
    logic [DATA_W-1:0]  ex_a_q, ex_b_q, ex_c_q;
    logic [15:0]        ex_imm_q;
    logic [IMEM_AW-1:0] ex_pc_q;

    logic               wb_valid_q, wb_we_q, wb_hlt_q;
    reg_idx_t           wb_rd_q;
    logic [DATA_W-1:0]  wb_result_q;
    logic [IMEM_AW-1:0] wb_pc_q;

    opcode_t            w_id_op;
    reg_idx_t           w_src [3];
    logic [DATA_W-1:0]  w_opnd [3];
    logic [15:0]        w_id_imm;

    assign w_id_op  = id_instr_q[OPC_MSB -: 4];
    assign w_src[0] = id_instr_q[RA_MSB -: 4];
    assign w_src[1] = id_instr_q[RB_MSB -: 4];
    assign w_src[2] = id_instr_q[RD_MSB -: 4];
    assign w_id_imm = id_instr_q[IMM_MSB -: 16];

    logic [DATA_W-1:0]  w_imm_ext, w_alu_a, w_alu_b, w_alu_res, w_ex_result;
    logic               w_alu_zero, w_ex_wr, w_taken, w_halt_ex, w_kill, w_dmem_we, w_imem_we;
    logic [DMEM_AW-1:0] w_dmem_addr;
    logic [IMEM_AW-1:0] w_target;

    assign w_imm_ext   = DATA_W'(ex_imm_q);
    assign w_alu_a     = (ex_op_q == OP_JEZ || ex_op_q == OP_JNZ) ? ex_c_q : ex_a_q;
    assign w_alu_b     = (ex_op_q == OP_MVI) ? w_imm_ext : ex_b_q;
    assign w_dmem_addr = DMEM_AW'(ex_a_q + w_imm_ext);
    assign w_target    = IMEM_AW'(ex_imm_q);

    riscy_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (ex_op_q),
        .a_i      (w_alu_a),
        .b_i      (w_alu_b),
        .result_o (w_alu_res),
        .zero_o   (w_alu_zero)
    );

    assign w_ex_result = (ex_op_q == OP_LOD) ? dmem_q[w_dmem_addr] : w_alu_res;
    assign w_ex_wr     = ex_valid_q && writes_rd(ex_op_q);
    assign w_taken     = ex_valid_q && ((ex_op_q == OP_JMP) ||
                                        (ex_op_q == OP_JEZ &&  w_alu_zero) ||
                                        (ex_op_q == OP_JNZ && !w_alu_zero));
    assign w_halt_ex   = ex_valid_q && (ex_op_q == OP_HLT);
    assign w_kill      = w_taken || w_halt_ex;
    assign w_dmem_we   = ex_valid_q && (ex_op_q == OP_STR);
    assign w_imem_we   = imem_we && (state_q == ST_IDLE || state_q == ST_HALTED);

    // EX result has priority over WB; the WB path also covers same-cycle write/read.
    for (genvar g = 0; g < 3; g++) begin : g_fwd
        assign w_opnd[g] = (w_ex_wr && ex_rd_q == w_src[g])                ? w_ex_result :
                           (wb_valid_q && wb_we_q && wb_rd_q == w_src[g]) ? wb_result_q :
                                                                             regs_q[w_src[g]];
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (run) begin
                    state_d    = ST_RUN;
                    pc_d       = '0;
                    if_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_halt_ex) begin
                    state_d    = ST_DRAIN;
                    if_valid_d = 1'b0;
                end else begin
                    pc_d = w_taken ? w_target : pc_q + IMEM_AW'(1);
                end
            end
            ST_DRAIN: begin
                if (wb_valid_q && wb_hlt_q) state_d = ST_HALTED;
            end
            default: state_d = ST_IDLE;
        endcase
        id_valid_d = if_valid_q && !w_kill;
        ex_valid_d = id_valid_q && !w_kill;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            if_valid_q  <= 1'b0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            ex_valid_q  <= 1'b0;
            ex_op_q     <= OP_HLT;
            ex_rd_q     <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_c_q      <= '0;
            ex_imm_q    <= '0;
            ex_pc_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_hlt_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            wb_pc_q     <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= imem_q[pc_q];
            id_pc_q     <= pc_q;
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= w_id_op;
            ex_rd_q     <= w_src[2];
            ex_a_q      <= w_opnd[0];
            ex_b_q      <= w_opnd[1];
            ex_c_q      <= w_opnd[2];
            ex_imm_q    <= w_id_imm;
            ex_pc_q     <= id_pc_q;
            wb_valid_q  <= ex_valid_q;
            wb_we_q     <= writes_rd(ex_op_q);
            wb_hlt_q    <= (ex_op_q == OP_HLT);
            wb_rd_q     <= ex_rd_q;
            wb_result_q <= w_ex_result;
            wb_pc_q     <= ex_pc_q;
            if (wb_valid_q && wb_we_q) regs_q[wb_rd_q] <= wb_result_q;
        end
    end

    // Memories hold their contents across reset; ex_valid_q clears asynchronously.
    always_ff @(posedge clock) begin
        if (w_imem_we) imem_q[imem_waddr] <= imem_wdata;
        if (w_dmem_we) dmem_q[w_dmem_addr] <= ex_c_q;
    end

    assign dbg_rdata    = regs_q[dbg_raddr];
    assign halted       = (state_q == ST_HALTED);
    assign retire_valid = wb_valid_q;
    assign retire_pc    = wb_pc_q;

endmodule
`default_nettype wire
